// File: rtl/spi_buffer_swap_ctrl_if.sv
// Bundle between the double-buffer sequencer and its surroundings: NITTA strobes,
// SPI word events, and the generated addresses, enables, limits and status.
interface spi_buffer_swap_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  // Strobes (signal_cycle, signal_wr, signal_oe, spi_word_done) are one-cycle
  // qualifiers sampled on the rising clk. spi_cs is a level. There is no back-pressure.
  // The *_en and nitta_rd_valid outputs are valid in the same cycle as their strobe.
  logic                  signal_cycle;
  logic                  signal_wr;
  logic                  signal_oe;
  logic                  spi_cs;
  logic                  spi_word_done;
  logic                  bank_sel;
  logic [ADDR_WIDTH-1:0] nitta_wr_addr;
  logic                  nitta_wr_en;
  logic [ADDR_WIDTH-1:0] nitta_rd_addr;
  logic                  nitta_rd_valid;
  logic [ADDR_WIDTH-1:0] spi_addr;
  logic                  spi_wr_en;
  logic [ADDR_WIDTH-1:0] spi_tx_limit;
  logic                  swap;
  logic                  swap_pending;
  logic                  flag_overflow;
  logic                  flag_underflow;

  modport master (
    output signal_cycle, signal_wr, signal_oe, spi_cs, spi_word_done,
    input  bank_sel, nitta_wr_addr, nitta_wr_en, nitta_rd_addr, nitta_rd_valid,
           spi_addr, spi_wr_en, spi_tx_limit, swap, swap_pending,
           flag_overflow, flag_underflow
  );

  modport slave (
    input  signal_cycle, signal_wr, signal_oe, spi_cs, spi_word_done,
    output bank_sel, nitta_wr_addr, nitta_wr_en, nitta_rd_addr, nitta_rd_valid,
           spi_addr, spi_wr_en, spi_tx_limit, swap, swap_pending,
           flag_overflow, flag_underflow
  );
endinterface

// File: rtl/spi_buffer_swap_ctrl.sv
// Bank-swap sequencer for the double-buffered SPI slave: address generation for both
// sides, frame swap on signal_cycle deferred until chip select is released.
module spi_buffer_swap_ctrl #(
  parameter int BUF_SIZE   = 10,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  spi_buffer_swap_ctrl_if.slave  bus,
  output logic [1:0]             o_dbg_state
);
  localparam logic [ADDR_WIDTH-1:0] LP_BUF = ADDR_WIDTH'(BUF_SIZE);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_WAIT_CS = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [ADDR_WIDTH-1:0] r_spi_addr;
  logic [ADDR_WIDTH-1:0] r_rd_limit;
  logic [ADDR_WIDTH-1:0] r_tx_limit;
  logic                  r_bank_sel;
  logic                  r_swap;
  logic                  r_swap_pending;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_wr_ok;
  logic                  w_spi_ok;
  logic                  w_rd_ok;
  logic                  w_wr_en;
  logic                  w_spi_en;
  logic                  w_enter_swap;
  logic                  w_enter_wait;
  logic [ADDR_WIDTH-1:0] w_wr_next;
  logic [ADDR_WIDTH-1:0] w_spi_next;

  assign w_wr_ok    = r_wr_addr < LP_BUF;
  assign w_spi_ok   = r_spi_addr < LP_BUF;
  assign w_rd_ok    = r_rd_addr < r_rd_limit;
  assign w_wr_en    = bus.signal_wr & w_wr_ok;
  assign w_spi_en   = bus.spi_word_done & w_spi_ok;
  // Counts include same-cycle strobes, so the limits captured at a swap see them.
  assign w_wr_next  = r_wr_addr + ADDR_WIDTH'(w_wr_en);
  assign w_spi_next = r_spi_addr + ADDR_WIDTH'(w_spi_en);

  assign w_enter_swap = ((r_state == ST_RUN) & bus.signal_cycle & bus.spi_cs & ~bus.spi_word_done)
                      | ((r_state == ST_WAIT_CS) & bus.spi_cs);
  assign w_enter_wait = (r_state == ST_RUN) & bus.signal_cycle & ~w_enter_swap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_wr_addr      <= '0;
      r_rd_addr      <= '0;
      r_spi_addr     <= '0;
      r_rd_limit     <= '0;
      r_tx_limit     <= '0;
      r_bank_sel     <= 1'b0;
      r_swap         <= 1'b0;
      r_swap_pending <= 1'b0;
      r_ovf          <= 1'b0;
      r_unf          <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN:     if (w_enter_swap) r_state <= ST_SWAP;
                    else if (w_enter_wait) r_state <= ST_WAIT_CS;
        ST_WAIT_CS: if (w_enter_swap) r_state <= ST_SWAP;
        default:    r_state <= ST_RUN;
      endcase
      r_swap         <= w_enter_swap;
      r_swap_pending <= w_enter_wait | ((r_state == ST_WAIT_CS) & ~bus.spi_cs);

      if (w_enter_swap) begin
        r_bank_sel <= ~r_bank_sel;
        r_rd_limit <= w_spi_next;
        r_tx_limit <= w_wr_next;
        r_wr_addr  <= '0;
        r_rd_addr  <= '0;
        r_spi_addr <= '0;
      end else begin
        r_wr_addr  <= w_wr_next;
        r_spi_addr <= w_spi_next;
        if (bus.signal_oe & w_rd_ok) r_rd_addr <= r_rd_addr + 1'b1;
      end

      if ((bus.signal_wr & ~w_wr_ok) | (bus.spi_word_done & ~w_spi_ok)) r_ovf <= 1'b1;
      if (bus.signal_oe & ~w_rd_ok) r_unf <= 1'b1;
    end
  end

  // Gated enables are also held low while reset is asserted.
  assign bus.nitta_wr_en    = rst & w_wr_en;
  assign bus.spi_wr_en      = rst & w_spi_en;
  assign bus.nitta_rd_valid = rst & w_rd_ok;

  assign bus.bank_sel       = r_bank_sel;
  assign bus.nitta_wr_addr  = r_wr_addr;
  assign bus.nitta_rd_addr  = r_rd_addr;
  assign bus.spi_addr       = r_spi_addr;
  assign bus.spi_tx_limit   = r_tx_limit;
  assign bus.swap           = r_swap;
  assign bus.swap_pending   = r_swap_pending;
  assign bus.flag_overflow  = r_ovf;
  assign bus.flag_underflow = r_unf;
  assign o_dbg_state        = r_state;
endmodule
